retospect_lif_cell: RTL and testbench



---
 rtl/retospect_fpna_pkg.sv | 14 +
 rtl/retospect_lif_cell_if.sv | 26 ++
 rtl/retospect_dendrite_sum.sv | 32 +++
 rtl/retospect_lif_cell.sv | 117 +++++++++++
 tb/tb_retospect_lif_cell.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/retospect_fpna_pkg.sv
// Shared types and constants for the FPNA neuron fabric cells.
package retospect_fpna_pkg;

  typedef enum logic {RUN, REFRACT} cell_state_t;

  localparam int unsigned CLKBUS_W = 8;

  // Configuration chain length: N weights, threshold, 3-bit decay select, refractory length.
  function automatic int unsigned cfg_len(input int unsigned n, input int unsigned w,
                                          input int unsigned p, input int unsigned r);
    return n * w + p + 3 + r;
  endfunction

endpackage

// File: rtl/retospect_lif_cell_if.sv
// Fabric-side signal bundle of one LIF cell; the cell uses the slave modport.
interface retospect_lif_cell_if
  import retospect_fpna_pkg::*;
#(
  parameter int unsigned N_DEND = 4,
  parameter int unsigned P_BITS = 8
);
  logic                reset_nn;
  logic                config_en;
  logic                bs_in;
  logic                bs_out;
  logic [CLKBUS_W-1:0] clockbus;
  logic [N_DEND-1:0]   dendrite;
  logic                axon;
  logic [P_BITS-1:0]   potential;

  modport master (
    output reset_nn, config_en, bs_in, clockbus, dendrite,
    input  bs_out, axon, potential
  );

  modport slave (
    input  reset_nn, config_en, bs_in, clockbus, dendrite,
    output bs_out, axon, potential
  );
endinterface

// File: rtl/retospect_dendrite_sum.sv
// Masked signed sum of dendrite weights added to a potential, clamped to [0, 2^P_BITS-1].
module retospect_dendrite_sum #(
  parameter int unsigned N_DEND = 4,
  parameter int unsigned W_BITS = 4,
  parameter int unsigned P_BITS = 8
) (
  input  logic [N_DEND*W_BITS-1:0] weights,
  input  logic [N_DEND-1:0]        mask,
  input  logic [P_BITS-1:0]        v_in,
  output logic [P_BITS-1:0]        v_out
);
  logic signed [P_BITS+1:0] acc;
  logic signed [P_BITS+1:0] total;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < N_DEND; i++) begin
      if (mask[i]) begin
        acc = acc + {{(P_BITS+2-W_BITS){weights[i*W_BITS+W_BITS-1]}}, weights[i*W_BITS +: W_BITS]};
      end
    end
    total = {2'b00, v_in} + acc;
    // Negative floors at zero; any bit at or above P_BITS on a positive total saturates.
    if (total[P_BITS+1]) begin
      v_out = '0;
    end else if (total[P_BITS]) begin
      v_out = '1;
    end else begin
      v_out = total[P_BITS-1:0];
    end
  end
endmodule

// File: rtl/retospect_lif_cell.sv
// Leaky integrate-and-fire cell: N weighted dendrites, threshold, refractory period,
// clockbus-strobed decay, configured through the serial bitstream chain.
module retospect_lif_cell
  import retospect_fpna_pkg::*;
#(
  parameter int unsigned N_DEND = 4,
  parameter int unsigned W_BITS = 4,
  parameter int unsigned P_BITS = 8,
  parameter int unsigned R_BITS = 3,
  parameter int unsigned INIT_V = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  retospect_lif_cell_if.slave bus
);
  localparam int unsigned L    = cfg_len(N_DEND, W_BITS, P_BITS, R_BITS);
  localparam int unsigned D_LO = R_BITS;
  localparam int unsigned T_LO = R_BITS + 3;

  // Chain layout, bs_in end first: w[0] at the top bits down to refr at bit 0.
  logic [L-1:0]             cfg_q, cfg_d;
  logic [P_BITS-1:0]        pot_q, pot_d;
  logic                     axon_q, axon_d;
  cell_state_t              state_q, state_d;
  logic [R_BITS-1:0]        cnt_q, cnt_d;

  logic [P_BITS-1:0]        thresh;
  logic [2:0]               dsel;
  logic [R_BITS-1:0]        refr;
  logic [N_DEND*W_BITS-1:0] weights;
  logic [N_DEND-1:0]        mask;
  logic [P_BITS-1:0]        v_dec, v_new;

  assign thresh = cfg_q[T_LO +: P_BITS];
  assign dsel   = cfg_q[D_LO +: 3];
  assign refr   = cfg_q[0 +: R_BITS];

  always_comb begin
    weights = '0;
    for (int unsigned i = 0; i < N_DEND; i++) begin
      weights[i*W_BITS +: W_BITS] = cfg_q[L-W_BITS*(i+1) +: W_BITS];
    end
  end

  assign v_dec = bus.clockbus[dsel] ? (pot_q >> 1) : pot_q;
  assign mask  = (state_q == RUN) ? bus.dendrite : '0;

  retospect_dendrite_sum #(
    .N_DEND(N_DEND),
    .W_BITS(W_BITS),
    .P_BITS(P_BITS)
  ) u_sum (
    .weights(weights),
    .mask   (mask),
    .v_in   (v_dec),
    .v_out  (v_new)
  );

  always_comb begin
    cfg_d   = cfg_q;
    pot_d   = pot_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    axon_d  = 1'b0;
    if (bus.reset_nn) begin
      pot_d   = P_BITS'(INIT_V);
      state_d = RUN;
      cnt_d   = '0;
    end else if (bus.config_en) begin
      cfg_d = {bus.bs_in, cfg_q[L-1:1]};
    end else begin
      unique case (state_q)
        RUN: begin
          if ((thresh != '0) && (v_new >= thresh)) begin
            axon_d = 1'b1;
            pot_d  = '0;
            if (refr != '0) begin
              state_d = REFRACT;
              cnt_d   = refr;
            end
          end else begin
            pot_d = v_new;
          end
        end
        REFRACT: begin
          // Mask is zero here, so v_new is the decayed potential alone.
          pot_d = v_new;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == R_BITS'(1)) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      pot_q   <= '0;
      axon_q  <= 1'b0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      cfg_q   <= cfg_d;
      pot_q   <= pot_d;
      axon_q  <= axon_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.bs_out    = cfg_q[0];
  assign bus.axon      = axon_q;
  assign bus.potential = pot_q;
endmodule

// File: tb/tb_retospect_lif_cell.sv
// Randomized and directed bench for retospect_lif_cell against a behavioural cell model.
module tb_retospect_lif_cell;
  localparam int N = 4, W = 4, P = 8, R = 3, INIT = 1;
  localparam int L = N * W + P + 3 + R;
  localparam int PMAX = (1 << P) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: chain as a bit queue, index 0 is the bs_out end.
  bit   mq[$];
  int   m_pot, m_axon, m_rl;

  retospect_lif_cell_if #(.N_DEND(N), .P_BITS(P)) bus ();

  retospect_lif_cell #(
    .N_DEND(N), .W_BITS(W), .P_BITS(P), .R_BITS(R), .INIT_V(INIT)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fld(input int lo, input int width);
    int v = 0;
    for (int j = 0; j < width; j++) v += int'(mq[lo + j]) << j;
    return v;
  endfunction

  function automatic int wt(input int i);
    int v = fld(3 + R + P + (N - 1 - i) * W, W);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < L; i++) mq.push_back(1'b0);
    m_pot = 0; m_axon = 0; m_rl = 0;
  endtask

  task automatic compare_all(input string phase);
    check({phase, ":potential"}, 32'(bus.potential), 32'(m_pot));
    check({phase, ":axon"}, 32'(bus.axon), 32'(m_axon));
    check({phase, ":bs_out"}, 32'(bus.bs_out), 32'(mq[0]));
  endtask

  task automatic step(input string phase);
    int v, th;
    @(posedge clk);
    if (bus.reset_nn) begin
      m_pot = INIT; m_axon = 0; m_rl = 0;
    end else if (bus.config_en) begin
      void'(mq.pop_front());
      mq.push_back(bus.bs_in);
      m_axon = 0;
    end else begin
      v = m_pot;
      if (bus.clockbus[fld(R, 3)]) v = v / 2;
      if (m_rl > 0) begin
        m_pot = v; m_rl--; m_axon = 0;
      end else begin
        for (int i = 0; i < N; i++) if (bus.dendrite[i]) v += wt(i);
        if (v < 0) v = 0;
        if (v > PMAX) v = PMAX;
        th = fld(R + 3, P);
        if (th != 0 && v >= th) begin
          m_axon = 1; m_pot = 0; m_rl = fld(0, R);
        end else begin
          m_pot = v; m_axon = 0;
        end
      end
    end
    #1;
    compare_all(phase);
  endtask

  task automatic set_bus(input logic [N-1:0] d);
    bus.dendrite = d;
    bus.clockbus = {6'($urandom), 2'b10};
  endtask

  task automatic cfg_load(input int w0, input int w1, input int w2, input int w3,
                          input int th, input int ds, input int rf);
    int ws[4];
    ws = '{w0, w1, w2, w3};
    bus.config_en = 1'b1;
    for (int j = 0; j < R; j++) begin bus.bs_in = 1'((rf >> j) & 1); step("cfg"); end
    for (int j = 0; j < 3; j++) begin bus.bs_in = 1'((ds >> j) & 1); step("cfg"); end
    for (int j = 0; j < P; j++) begin bus.bs_in = 1'((th >> j) & 1); step("cfg"); end
    for (int i = N - 1; i >= 0; i--)
      for (int j = 0; j < W; j++) begin bus.bs_in = 1'((ws[i] >> j) & 1); step("cfg"); end
    bus.config_en = 1'b0;
    bus.bs_in = 1'b0;
  endtask

  task automatic rearm();
    bus.reset_nn = 1'b1; step("rearm");
    bus.reset_nn = 1'b0;
  endtask

  task automatic run(input int n, input logic [N-1:0] d, input string phase);
    for (int k = 0; k < n; k++) begin set_bus(d); step(phase); end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst:potential", 32'(bus.potential), 32'd0);
    check("async_rst:axon", 32'(bus.axon), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.reset_nn = 1'b0; bus.config_en = 1'b0; bus.bs_in = 1'b0;
    bus.dendrite = '0; bus.clockbus = 8'b0000_0010;
    model_reset();
    #12;
    check("reset:potential", 32'(bus.potential), 32'd0);
    check("reset:axon", 32'(bus.axon), 32'd0);
    check("reset:bs_out", 32'(bus.bs_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Readback: random pattern in, zeros behind it, bs_out replays it.
    bus.config_en = 1'b1;
    for (int k = 0; k < 2 * L; k++) begin
      bus.bs_in = (k < L) ? 1'($urandom) : 1'b0;
      step("readback");
    end
    bus.config_en = 1'b0;

    // Integrate and fire with refractory period.
    cfg_load(3, 0, 0, 0, 10, 0, 2);
    rearm();
    run(8, 4'b0001, "fire");

    // Simultaneous, inhibitory, saturation, floor.
    cfg_load(2, -8, 7, 7, 0, 0, 0);
    rearm();
    run(2, 4'b1000, "mix");
    run(1, 4'b1011, "mix");
    run(45, 4'b0100, "sat");
    run(1, 4'b0000, "sat");
    run(40, 4'b0010, "floor");

    // Decay via constant-1 clockbus line.
    cfg_load(4, 0, 0, 0, 0, 1, 0);
    rearm();
    run(50, 4'b0001, "decay_in");
    run(6, 4'b0000, "decay");

    // Async reset during refractory, then all-zero readback.
    cfg_load(7, 7, 0, 0, 12, 0, 5);
    rearm();
    run(3, 4'b0011, "refract");
    async_reset();
    run(2, 4'b0011, "post_rst");
    bus.config_en = 1'b1;
    for (int k = 0; k < L; k++) begin bus.bs_in = 1'($urandom); step("zero_readback"); end

    // reset_nn wins over config_en.
    bus.reset_nn = 1'b1;
    step("nn_over_cfg");
    bus.reset_nn = 1'b0; bus.config_en = 1'b0;

    // refr=0, thresh=1: fires every cycle.
    cfg_load(1, 0, 0, 0, 1, 0, 0);
    rearm();
    run(6, 4'b0001, "every_cycle");

    // Randomized traffic.
    for (int blk = 0; blk < 50; blk++) begin
      cfg_load($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 60), $urandom_range(0, 7),
               $urandom_range(0, 7));
      rearm();
      for (int k = 0; k < 40; k++) begin
        set_bus(4'($urandom));
        bus.reset_nn  = ($urandom_range(0, 29) == 0);
        bus.config_en = ($urandom_range(0, 39) == 0);
        bus.bs_in     = 1'($urandom);
        step("random");
        if ($urandom_range(0, 199) == 0) async_reset();
      end
      bus.reset_nn = 1'b0; bus.config_en = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
